// File: rtl/qick_xcom_pkg.sv
// Shared types and widths for the XCOM command arbiter: opcode/data widths, queue entry layout,
// arbiter FSM states and the opcode bit that steers a command to the local channel.
package qick_xcom_pkg;

    localparam int OP_W    = 8;
    localparam int DT_W    = 32;
    localparam int CMD_W   = OP_W + DT_W;
    localparam int LOC_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKL = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_TP = 1'b0,
        SRC_PS = 1'b1
    } src_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [DT_W-1:0] dt;
    } cmd_t;

    function automatic logic is_local(input logic [OP_W-1:0] op);
        return op[LOC_BIT];
    endfunction

endpackage

// File: rtl/qick_xcom_cmd_fifo.sv
// Small command queue, 2**AW entries; a push is visible at the head one cycle later.
// Pushes while full and pops while empty are ignored; head is read combinationally.
module qick_xcom_cmd_fifo #(
    parameter int AW = 2,
    parameter int W  = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the registered count, so a pop never frees room in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qick_xcom_cmd_arb.sv
// Arbitrates tProc and PS command queues onto the XCOM core over a 4-phase req/ack handshake.
// Enqueue-to-req is 2 cycles from idle; one command in flight, a new req waits for ack to drop.
module qick_xcom_cmd_arb
    import qick_xcom_pkg::*;
#(
    parameter int FIFO_AW  = 2,
    parameter int ARB_MODE = 0
) (
    input  logic             c_clk_i,
    input  logic             c_rst_i,
    input  logic             tp_en_i,
    input  logic [OP_W-1:0]  tp_op_i,
    input  logic [DT_W-1:0]  tp_dt_i,
    output logic             tp_full_o,
    input  logic             ps_en_i,
    input  logic [OP_W-1:0]  ps_op_i,
    input  logic [DT_W-1:0]  ps_dt_i,
    output logic             ps_full_o,
    output logic             cmd_loc_req_o,
    input  logic             cmd_loc_ack_i,
    output logic             cmd_net_req_o,
    input  logic             cmd_net_ack_i,
    output logic [OP_W-1:0]  cmd_op_o,
    output logic [DT_W-1:0]  cmd_dt_o,
    output logic             busy_o,
    input  logic             clr_i,
    output logic [1:0]       ovf_o,
    output logic [7:0]       cmd_cnt_o
);

    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    arb_state_t       state;
    src_t             rr_next;
    logic             sel_loc;
    logic             sel_ack;
    cmd_t             tp_in;
    cmd_t             ps_in;
    cmd_t             tp_head;
    cmd_t             ps_head;
    cmd_t             win;
    logic             tp_empty;
    logic             ps_empty;
    logic [FIFO_AW:0] tp_count;
    logic [FIFO_AW:0] ps_count;
    logic             grant_tp;
    logic             grant_ps;
    logic             tp_ovf_evt;
    logic             ps_ovf_evt;

    assign tp_in = '{op: tp_op_i, dt: tp_dt_i};
    assign ps_in = '{op: ps_op_i, dt: ps_dt_i};

    qick_xcom_cmd_fifo #(.AW(FIFO_AW), .W(CMD_W)) u_tp_fifo (
        .clk   (c_clk_i),
        .rst   (c_rst_i),
        .push  (tp_en_i),
        .din   (tp_in),
        .pop   (grant_tp),
        .dout  (tp_head),
        .full  (tp_full_o),
        .empty (tp_empty),
        .count (tp_count)
    );

    qick_xcom_cmd_fifo #(.AW(FIFO_AW), .W(CMD_W)) u_ps_fifo (
        .clk   (c_clk_i),
        .rst   (c_rst_i),
        .push  (ps_en_i),
        .din   (ps_in),
        .pop   (grant_ps),
        .dout  (ps_head),
        .full  (ps_full_o),
        .empty (ps_empty),
        .count (ps_count)
    );

    assign tp_ovf_evt = tp_en_i && (tp_count == FULL_CNT);
    assign ps_ovf_evt = ps_en_i && (ps_count == FULL_CNT);

    // A new overflow in the same cycle as clr_i keeps its flag set.
    always_ff @(posedge c_clk_i or posedge c_rst_i) begin
        if (c_rst_i) begin
            ovf_o <= 2'b00;
        end else begin
            ovf_o <= {ps_ovf_evt, tp_ovf_evt} | (ovf_o & {2{~clr_i}});
        end
    end

    always_comb begin
        grant_tp = 1'b0;
        grant_ps = 1'b0;
        if (state == ST_IDLE) begin
            if (!tp_empty && !ps_empty) begin
                if (ARB_MODE == 1 || rr_next == SRC_TP) begin
                    grant_tp = 1'b1;
                end else begin
                    grant_ps = 1'b1;
                end
            end else if (!tp_empty) begin
                grant_tp = 1'b1;
            end else if (!ps_empty) begin
                grant_ps = 1'b1;
            end
        end
    end

    assign win     = grant_ps ? ps_head : tp_head;
    assign sel_ack = sel_loc ? cmd_loc_ack_i : cmd_net_ack_i;
    assign busy_o  = (state != ST_IDLE);

    always_ff @(posedge c_clk_i or posedge c_rst_i) begin
        if (c_rst_i) begin
            state         <= ST_IDLE;
            rr_next       <= SRC_TP;
            sel_loc       <= 1'b0;
            cmd_loc_req_o <= 1'b0;
            cmd_net_req_o <= 1'b0;
            cmd_op_o      <= '0;
            cmd_dt_o      <= '0;
            cmd_cnt_o     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_tp || grant_ps) begin
                        cmd_op_o      <= win.op;
                        cmd_dt_o      <= win.dt;
                        sel_loc       <= is_local(win.op);
                        cmd_loc_req_o <= is_local(win.op);
                        cmd_net_req_o <= !is_local(win.op);
                        rr_next       <= grant_tp ? SRC_PS : SRC_TP;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sel_ack) begin
                        cmd_loc_req_o <= 1'b0;
                        cmd_net_req_o <= 1'b0;
                        cmd_cnt_o     <= cmd_cnt_o + 8'd1;
                        state         <= ST_ACKL;
                    end
                end
                ST_ACKL: begin
                    if (!sel_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qick_xcom_cmd_arb.sv
// Directed bench for qick_xcom_cmd_arb: a round-robin instance driven by hand-written handshakes
// and a fixed-priority instance answered by an automatic ack responder.
module tb_qick_xcom_cmd_arb;

    logic        c_clk = 1'b0;
    logic        c_rst;
    logic        tp_en;
    logic [7:0]  tp_op;
    logic [31:0] tp_dt;
    logic        ps_en;
    logic [7:0]  ps_op;
    logic [31:0] ps_dt;
    logic        loc_ack;
    logic        net_ack;
    logic        clr;

    logic        tp_full, ps_full, loc_req, net_req, busy;
    logic [7:0]  cmd_op, cmd_cnt;
    logic [31:0] cmd_dt;
    logic [1:0]  ovf;

    logic        fp_tp_full, fp_ps_full, fp_loc_req, fp_net_req, fp_busy;
    logic        fp_loc_ack = 1'b0;
    logic        fp_net_ack = 1'b0;
    logic [7:0]  fp_op, fp_cnt;
    logic [31:0] fp_dt;
    logic [1:0]  fp_ovf;

    int errors = 0;
    int checks = 0;

    logic [7:0]  got_op;
    logic [31:0] got_dt;
    logic [7:0]  fp_log[$];
    bit          fp_log_en = 1'b0;
    logic        fp_req_q = 1'b0;

    always #5 c_clk = ~c_clk;

    qick_xcom_cmd_arb #(.FIFO_AW(2), .ARB_MODE(0)) dut (
        .c_clk_i(c_clk), .c_rst_i(c_rst),
        .tp_en_i(tp_en), .tp_op_i(tp_op), .tp_dt_i(tp_dt), .tp_full_o(tp_full),
        .ps_en_i(ps_en), .ps_op_i(ps_op), .ps_dt_i(ps_dt), .ps_full_o(ps_full),
        .cmd_loc_req_o(loc_req), .cmd_loc_ack_i(loc_ack),
        .cmd_net_req_o(net_req), .cmd_net_ack_i(net_ack),
        .cmd_op_o(cmd_op), .cmd_dt_o(cmd_dt), .busy_o(busy),
        .clr_i(clr), .ovf_o(ovf), .cmd_cnt_o(cmd_cnt)
    );

    qick_xcom_cmd_arb #(.FIFO_AW(2), .ARB_MODE(1)) dut_fp (
        .c_clk_i(c_clk), .c_rst_i(c_rst),
        .tp_en_i(tp_en), .tp_op_i(tp_op), .tp_dt_i(tp_dt), .tp_full_o(fp_tp_full),
        .ps_en_i(ps_en), .ps_op_i(ps_op), .ps_dt_i(ps_dt), .ps_full_o(fp_ps_full),
        .cmd_loc_req_o(fp_loc_req), .cmd_loc_ack_i(fp_loc_ack),
        .cmd_net_req_o(fp_net_req), .cmd_net_ack_i(fp_net_ack),
        .cmd_op_o(fp_op), .cmd_dt_o(fp_dt), .busy_o(fp_busy),
        .clr_i(clr), .ovf_o(fp_ovf), .cmd_cnt_o(fp_cnt)
    );

    // Core model for the fixed-priority instance: ack follows req one cycle later.
    always @(posedge c_clk) begin
        fp_loc_ack <= fp_loc_req;
        fp_net_ack <= fp_net_req;
    end

    always @(negedge c_clk) begin
        if (fp_log_en && (fp_loc_req || fp_net_req) && !fp_req_q) fp_log.push_back(fp_op);
        fp_req_q = fp_loc_req || fp_net_req;
    end

    typedef struct {
        logic        tp_en;
        logic [7:0]  tp_op;
        logic [31:0] tp_dt;
        logic        loc_ack;
        logic        exp_loc;
        logic        exp_busy;
        logic [7:0]  exp_op;
        logic [31:0] exp_dt;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        tp_en = 0; tp_op = 0; tp_dt = 0;
        ps_en = 0; ps_op = 0; ps_dt = 0;
        loc_ack = 0; net_ack = 0; clr = 0;
        c_rst = 1;
        repeat (2) @(negedge c_clk);
        c_rst = 0;
        @(negedge c_clk);
    endtask

    // Full 4-phase handshake on whichever channel the DUT requests; every wait is bounded.
    task automatic serve(output logic [7:0] op, output logic [31:0] dt);
        int n;
        op = '0;
        dt = '0;
        n = 0;
        while (!(loc_req || net_req) && n < 20) begin @(negedge c_clk); n++; end
        chk("serve_req_seen", loc_req || net_req, 1);
        if (!(loc_req || net_req)) return;
        op = cmd_op;
        dt = cmd_dt;
        if (loc_req) loc_ack = 1; else net_ack = 1;
        n = 0;
        while ((loc_req || net_req) && n < 20) begin @(negedge c_clk); n++; end
        chk("serve_req_drop", loc_req || net_req, 0);
        loc_ack = 0;
        net_ack = 0;
        n = 0;
        while (busy && n < 20) begin @(negedge c_clk); n++; end
        chk("serve_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rr_exp[4];
        logic [7:0]  fp_exp[4];

        vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        8'd0};
        vecs[1] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 8'd0};
        vecs[2] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 8'd0};
        vecs[3] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 8'd0};
        vecs[4] = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 8'd1};
        vecs[5] = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 8'd1};
        vecs[6] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF, 8'd1};
        rr_exp = '{8'h11, 8'h12, 8'h13, 8'h14};
        fp_exp = '{8'h11, 8'h13, 8'h12, 8'h14};

        // Reset state, sampled while reset is held.
        tp_en = 0; tp_op = 0; tp_dt = 0; ps_en = 0; ps_op = 0; ps_dt = 0;
        loc_ack = 0; net_ack = 0; clr = 0; c_rst = 1;
        @(negedge c_clk);
        chk("rst_loc_req", loc_req, 0);
        chk("rst_net_req", net_req, 0);
        chk("rst_op", cmd_op, 0);
        chk("rst_dt", cmd_dt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cnt", cmd_cnt, 0);
        chk("rst_tp_full", tp_full, 0);
        chk("rst_ps_full", ps_full, 0);
        do_reset();

        // Single tProc command, cycle by cycle.
        for (int i = 0; i < 7; i++) begin
            tp_en = vecs[i].tp_en; tp_op = vecs[i].tp_op; tp_dt = vecs[i].tp_dt;
            loc_ack = vecs[i].loc_ack;
            @(negedge c_clk);
            chk($sformatf("vec%0d_loc_req", i), loc_req, vecs[i].exp_loc);
            chk($sformatf("vec%0d_net_req", i), net_req, 0);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_op", i), cmd_op, vecs[i].exp_op);
            chk($sformatf("vec%0d_dt", i), cmd_dt, vecs[i].exp_dt);
            chk($sformatf("vec%0d_cnt", i), cmd_cnt, vecs[i].exp_cnt);
        end
        loc_ack = 0;

        // Two commands per source in the same cycles: round-robin vs fixed priority.
        do_reset();
        fp_log.delete();
        fp_log_en = 1;
        tp_en = 1; tp_op = 8'h11; tp_dt = 32'd1; ps_en = 1; ps_op = 8'h12; ps_dt = 32'd2;
        @(negedge c_clk);
        tp_op = 8'h13; tp_dt = 32'd3; ps_op = 8'h14; ps_dt = 32'd4;
        @(negedge c_clk);
        tp_en = 0; ps_en = 0;
        for (int i = 0; i < 4; i++) begin
            serve(got_op, got_dt);
            chk($sformatf("rr_order%0d_op", i), got_op, rr_exp[i]);
            chk($sformatf("rr_order%0d_dt", i), got_dt, {24'd0, rr_exp[i]} - 32'h10);
        end
        repeat (10) @(negedge c_clk);
        fp_log_en = 0;
        chk("fp_log_size", fp_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fp_order%0d_op", i), (i < fp_log.size()) ? fp_log[i] : 8'h00, fp_exp[i]);
        end
        chk("fp_cnt", fp_cnt, 4);
        chk("fp_busy", fp_busy, 0);
        chk("fp_last_dt", fp_dt, 32'd4);
        chk("fp_ovf", fp_ovf, 0);
        chk("fp_fulls", {fp_tp_full, fp_ps_full}, 0);

        // Overflow: hold a PS command in REQ so the tProc queue cannot drain.
        do_reset();
        ps_en = 1; ps_op = 8'h01; ps_dt = 32'h100;
        @(negedge c_clk);
        ps_en = 0;
        @(negedge c_clk);
        chk("ovf_hold_net_req", net_req, 1);
        for (int i = 0; i < 5; i++) begin
            tp_en = 1; tp_op = 8'h20 + 8'(i); tp_dt = 32'(i);
            @(negedge c_clk);
            if (i == 2) chk("tp_full_after_3", tp_full, 0);
            if (i == 3) chk("tp_full_after_4", tp_full, 1);
        end
        tp_en = 0;
        chk("ovf_after_5th", ovf, 2'b01);
        chk("tp_full_hold", tp_full, 1);
        tp_en = 1; tp_op = 8'h2F; clr = 1;
        @(negedge c_clk);
        tp_en = 0;
        chk("ovf_clr_vs_new", ovf, 2'b01);
        @(negedge c_clk);
        clr = 0;
        chk("ovf_cleared", ovf, 2'b00);
        serve(got_op, got_dt);
        chk("ovf_first_ps_op", got_op, 8'h01);
        for (int i = 0; i < 4; i++) begin
            serve(got_op, got_dt);
            chk($sformatf("ovf_tp%0d_op", i), got_op, 8'h20 + 8'(i));
            chk($sformatf("ovf_tp%0d_dt", i), got_dt, 32'(i));
        end
        chk("ovf_tp_full_end", tp_full, 0);
        chk("ovf_cnt_end", cmd_cnt, 5);

        // Network routing with a spurious local ack.
        do_reset();
        ps_en = 1; ps_op = 8'h05; ps_dt = 32'h55;
        @(negedge c_clk);
        ps_en = 0;
        @(negedge c_clk);
        chk("net_req_up", net_req, 1);
        chk("net_loc_low", loc_req, 0);
        chk("net_op", cmd_op, 8'h05);
        loc_ack = 1;
        repeat (3) @(negedge c_clk);
        chk("net_spurious_req", net_req, 1);
        chk("net_spurious_loc", loc_req, 0);
        chk("net_spurious_busy", busy, 1);
        chk("net_spurious_cnt", cmd_cnt, 0);
        loc_ack = 0; net_ack = 1;
        @(negedge c_clk);
        chk("net_req_drop", net_req, 0);
        chk("net_cnt", cmd_cnt, 1);
        net_ack = 0;
        @(negedge c_clk);
        chk("net_busy_low", busy, 0);

        // Asynchronous reset while in REQ with one command still queued.
        tp_en = 1; tp_op = 8'h10; tp_dt = 32'hA;
        @(negedge c_clk);
        tp_op = 8'h11; tp_dt = 32'hB;
        @(negedge c_clk);
        tp_en = 0;
        chk("arst_pre_req", loc_req, 1);
        c_rst = 1;
        #1;
        chk("arst_req", loc_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", cmd_cnt, 0);
        chk("arst_op", cmd_op, 0);
        repeat (2) @(negedge c_clk);
        c_rst = 0;
        repeat (5) @(negedge c_clk);
        chk("arst_no_req", loc_req || net_req, 0);
        chk("arst_idle", busy, 0);

        // Counter wrap after 256 issued commands.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            tp_en = 1; tp_op = 8'h10; tp_dt = 32'(i);
            @(negedge c_clk);
            tp_en = 0;
            serve(got_op, got_dt);
            if (i == 254) chk("wrap_cnt_255", cmd_cnt, 8'd255);
        end
        chk("wrap_cnt_0", cmd_cnt, 8'd0);
        chk("wrap_last_dt", got_dt, 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
